// File: rtl/change_pkg.sv
// Shared encodings for the change dispenser: FSM states, hopper coin codes
// and the rupee value of each denomination.
package change_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_ISSUE  = 3'd2,
        S_DONE   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [1:0] COIN_10 = 2'b00;
    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_2  = 2'b10;
    localparam logic [1:0] COIN_1  = 2'b11;

    localparam int DENOM_10 = 10;
    localparam int DENOM_5  = 5;
    localparam int DENOM_2  = 2;
    localparam int DENOM_1  = 1;

endpackage

// File: rtl/change_denom_sel.sv
// Picks the largest coin not exceeding the amount owed. Purely combinational so
// the vending controller can reuse it for change-feasibility checks.
module change_denom_sel
    import change_pkg::*;
#(
    parameter int AMT_W = 5
) (
    input  logic [AMT_W-1:0] remaining,
    output logic [1:0]       coin_sel,
    output logic [AMT_W-1:0] denom
);

    // A zero amount falls through to Rs.1; callers never issue a coin for it.
    always_comb begin
        coin_sel = COIN_1;
        denom    = AMT_W'(DENOM_1);
        if (remaining >= AMT_W'(DENOM_10)) begin
            coin_sel = COIN_10;
            denom    = AMT_W'(DENOM_10);
        end else if (remaining >= AMT_W'(DENOM_5)) begin
            coin_sel = COIN_5;
            denom    = AMT_W'(DENOM_5);
        end else if (remaining >= AMT_W'(DENOM_2)) begin
            coin_sel = COIN_2;
            denom    = AMT_W'(DENOM_2);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a requested change amount to the coin hopper one coin at a time,
// largest denomination first, with a latched fault on hopper ack timeout.
//
// state  | meaning
// IDLE   | ready for a change request
// SELECT | register the next coin for the amount still owed
// ISSUE  | coin_valid high, waiting for coin_ack or timeout
// DONE   | one-cycle change_done pulse
// FAULT  | hopper timed out; owed amount frozen until fault_clear
module change_dispenser
    import change_pkg::*;
#(
    parameter int AMT_W       = 5,
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amount,
    output logic             change_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    input  logic             coin_ack,
    output logic             change_done,
    output logic [2:0]       coin_count,
    output logic [AMT_W-1:0] remaining,
    output logic             fault,
    input  logic             fault_clear
);

    state_t           state, state_nx;
    logic [AMT_W-1:0] remaining_nx;
    logic [AMT_W-1:0] cur_denom, cur_denom_nx;
    logic [AMT_W-1:0] pick_denom;
    logic [1:0]       coin_sel_nx, pick_sel;
    logic [2:0]       count_nx;
    logic [TO_W-1:0]  to_cnt, to_cnt_nx;

    change_denom_sel #(.AMT_W(AMT_W)) u_denom_sel (
        .remaining (remaining),
        .coin_sel  (pick_sel),
        .denom     (pick_denom)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            remaining  <= '0;
            cur_denom  <= '0;
            coin_sel   <= COIN_10;
            coin_count <= '0;
            to_cnt     <= '0;
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            cur_denom  <= cur_denom_nx;
            coin_sel   <= coin_sel_nx;
            coin_count <= count_nx;
            to_cnt     <= to_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        cur_denom_nx = cur_denom;
        coin_sel_nx  = coin_sel;
        count_nx     = coin_count;
        to_cnt_nx    = to_cnt;
        case (state)
            S_IDLE: begin
                if (change_valid) begin
                    remaining_nx = change_amount;
                    count_nx     = '0;
                    state_nx     = (change_amount == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                coin_sel_nx  = pick_sel;
                cur_denom_nx = pick_denom;
                to_cnt_nx    = '0;
                state_nx     = S_ISSUE;
            end
            S_ISSUE: begin
                // An ack on the last allowed cycle takes priority over the timeout.
                if (coin_ack) begin
                    remaining_nx = remaining - cur_denom;
                    count_nx     = coin_count + 3'd1;
                    state_nx     = (remaining_nx == '0) ? S_DONE : S_SELECT;
                end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    state_nx = S_FAULT;
                end else begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
            end
            S_DONE: state_nx = S_IDLE;
            S_FAULT: begin
                if (fault_clear) begin
                    remaining_nx = '0;
                    state_nx     = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign change_ready = (state == S_IDLE);
    assign coin_valid   = (state == S_ISSUE);
    assign change_done  = (state == S_DONE);
    assign fault        = (state == S_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: tests push expected coins and
// transaction results; a monitor compares them as the DUT presents outputs.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic       change_valid;
    logic [4:0] change_amount;
    logic       change_ready;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       coin_ack;
    logic       change_done;
    logic [2:0] coin_count;
    logic [4:0] remaining;
    logic       fault;
    logic       fault_clear;

    int n_checks = 0;
    int n_pass   = 0;
    int done_seen = 0;
    int coins_popped = 0;
    int ack_delay = 1;
    int wait_cnt  = 0;

    logic [1:0] exp_coins[$];
    int         exp_done[$];

    change_dispenser #(.AMT_W(5), .ACK_TIMEOUT(16), .TO_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .change_ready  (change_ready),
        .coin_valid    (coin_valid),
        .coin_sel      (coin_sel),
        .coin_ack      (coin_ack),
        .change_done   (change_done),
        .coin_count    (coin_count),
        .remaining     (remaining),
        .fault         (fault),
        .fault_clear   (fault_clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // seq[1:0] is the first coin, seq[3:2] the second, and so on.
    task automatic expect_txn(input int n, input logic [9:0] seq, input int count);
        logic [9:0] s;
        s = seq;
        for (int i = 0; i < n; i++) begin
            exp_coins.push_back(s[1:0]);
            s = s >> 2;
        end
        if (count >= 0) exp_done.push_back(count);
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the accept edge.
    task automatic request(input logic [4:0] amt);
        chk("ready_before_req", int'(change_ready), 1);
        change_valid  = 1'b1;
        change_amount = amt;
        @(posedge clock); #1;
        change_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            if (done_seen != start) break;
        end
        #1;
        chk("done_within_budget", done_seen - start, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},  int'(change_ready), 1);
        chk({tag, "_cvalid"}, int'(coin_valid), 0);
        chk({tag, "_sel"},    int'(coin_sel), 0);
        chk({tag, "_done"},   int'(change_done), 0);
        chk({tag, "_count"},  int'(coin_count), 0);
        chk({tag, "_remain"}, int'(remaining), 0);
        chk({tag, "_fault"},  int'(fault), 0);
    endtask

    // Hopper model: acks ack_delay cycles after it first sees coin_valid.
    initial begin
        coin_ack = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (coin_valid && !reset) begin
                coin_ack = (wait_cnt == ack_delay);
                wait_cnt++;
            end else begin
                coin_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (coin_valid) begin
                    chk("coin_expected", int'(exp_coins.size() > 0), 1);
                    if (exp_coins.size() > 0) begin
                        chk("coin_sel", int'(coin_sel), int'(exp_coins[0]));
                        if (coin_ack) begin
                            void'(exp_coins.pop_front());
                            coins_popped++;
                        end
                    end
                end
                if (change_done) begin
                    chk("done_expected", int'(exp_done.size() > 0), 1);
                    if (exp_done.size() > 0) begin
                        chk("done_count", int'(coin_count), exp_done.pop_front());
                        chk("done_remaining", int'(remaining), 0);
                    end
                    done_seen++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        reset = 1'b1;
        change_valid = 1'b0;
        change_amount = '0;
        fault_clear = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // 18 = 10+5+2+1
        ack_delay = 1;
        start = done_seen;
        expect_txn(4, 10'b00_11_10_01_00, 4);
        request(5'd18);
        wait_done(start, 60);
        chk("a18_remaining", int'(remaining), 0);

        // 29 = 10+10+5+2+2; coin_valid low in the cycle after accept, high in the next
        start = done_seen;
        expect_txn(5, 10'b10_10_01_00_00, 5);
        request(5'd29);
        chk("a29_lat_select", int'(coin_valid), 0);
        @(posedge clock); #1;
        chk("a29_lat_issue", int'(coin_valid), 1);
        wait_done(start, 60);

        // zero amount: change_done in the cycle right after accept, no coins
        start = done_seen;
        expect_txn(0, 10'b0, 0);
        request(5'd0);
        chk("a0_done_pulse", int'(change_done), 1);
        chk("a0_count", int'(coin_count), 0);
        wait_done(start, 10);

        // 7 = 5+2 with slow hopper, stray request of 9 mid-transaction
        ack_delay = 3;
        start = done_seen;
        expect_txn(2, 10'b00_00_00_10_01, 2);
        request(5'd7);
        repeat (3) @(posedge clock);
        #1;
        change_valid = 1'b1;
        change_amount = 5'd9;
        @(posedge clock); #1;
        change_valid = 1'b0;
        wait_done(start, 60);
        repeat (4) @(posedge clock);
        #1;
        chk("a7_idle_after", int'(change_ready), 1);
        chk("a7_no_coin_after", int'(coin_valid), 0);
        chk("a7_count_hold", int'(coin_count), 2);

        // 12 with no ack: fault exactly 16 cycles after coin_valid rises
        ack_delay = 1000;
        expect_txn(1, 10'b00_00_00_00_00, -1);
        request(5'd12);
        @(posedge clock); #1;
        chk("to_cvalid_rise", int'(coin_valid), 1);
        repeat (15) @(posedge clock);
        #1;
        chk("to_no_fault_15", int'(fault), 0);
        @(posedge clock); #1;
        chk("to_fault_16", int'(fault), 1);
        chk("to_remaining", int'(remaining), 12);
        chk("to_cvalid_low", int'(coin_valid), 0);
        chk("to_ready_low", int'(change_ready), 0);
        exp_coins.delete();
        repeat (3) @(posedge clock);
        #1;
        chk("to_fault_latched", int'(fault), 1);
        fault_clear = 1'b1;
        @(posedge clock); #1;
        fault_clear = 1'b0;
        chk("clr_ready", int'(change_ready), 1);
        chk("clr_fault", int'(fault), 0);
        chk("clr_remaining", int'(remaining), 0);
        chk("clr_no_done", int'(change_done), 0);

        // 12 = 10+2 with each ack on the 16th cycle: ack wins over timeout
        ack_delay = 15;
        start = done_seen;
        expect_txn(2, 10'b00_00_00_10_00, 2);
        request(5'd12);
        wait_done(start, 80);
        chk("ack16_no_fault", int'(fault), 0);

        // 25: asynchronous reset just after the first coin is taken
        ack_delay = 1;
        start = coins_popped;
        expect_txn(3, 10'b00_00_01_00_00, -1);
        request(5'd25);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            if (coins_popped != start) break;
        end
        chk("rst_first_coin", coins_popped - start, 1);
        #3 reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        exp_coins.delete();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // 7 = 5+2 after reset
        start = done_seen;
        expect_txn(2, 10'b00_00_00_10_01, 2);
        request(5'd7);
        wait_done(start, 60);
        chk("post_rst_count", int'(coin_count), 2);

        repeat (3) @(posedge clock);
        chk("coin_q_empty", exp_coins.size(), 0);
        chk("done_q_empty", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
